// File: rtl/reg_access_arbiter_pkg.sv
// reg_arb_pkg: shared types for the register access arbiter.
// Holds the FSM state enum, the default data width and the latched request bundle.
package reg_arb_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int ADDR_W_MAX = 16;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      RESP
   } arb_state_t;

   typedef struct packed {
      logic                  write;
      logic [ADDR_W_MAX-1:0] addr;
      logic [DATA_W_DEF-1:0] wdata;
   } req_t;

endpackage

// File: rtl/reg_access_arbiter_if.sv
// reg_access_arbiter_if: requester + register-map bus of the arbiter.
// slave modport = arbiter view, master modport = requesters/register map view.
interface reg_access_arbiter_if #(
   parameter int NUM_MASTERS  = 2,
   parameter int POWEROF2REGS = 8,
   parameter int ADDR_W       = 3,
   parameter int DATA_W       = 32
);

   logic [NUM_MASTERS-1:0]         req_valid;
   logic [NUM_MASTERS-1:0]         req_write;
   logic [NUM_MASTERS*ADDR_W-1:0]  req_addr;
   logic [NUM_MASTERS*DATA_W-1:0]  req_wdata;
   logic [NUM_MASTERS-1:0]         req_ready;
   logic [NUM_MASTERS-1:0]         rsp_valid;
   logic [DATA_W-1:0]              rsp_rdata;
   logic                           rsp_err;
   logic [POWEROF2REGS-1:0]        write_en;
   logic [POWEROF2REGS-1:0]        read_en;
   logic [DATA_W-1:0]              data_in;
   logic [POWEROF2REGS*DATA_W-1:0] data_out;

   modport slave (
      input  req_valid,
      input  req_write,
      input  req_addr,
      input  req_wdata,
      input  data_out,
      output req_ready,
      output rsp_valid,
      output rsp_rdata,
      output rsp_err,
      output write_en,
      output read_en,
      output data_in
   );

   modport master (
      output req_valid,
      output req_write,
      output req_addr,
      output req_wdata,
      output data_out,
      input  req_ready,
      input  rsp_valid,
      input  rsp_rdata,
      input  rsp_err,
      input  write_en,
      input  read_en,
      input  data_in
   );

endinterface

// File: rtl/reg_access_arbiter_rr_arbiter.sv
// rr_arbiter: picks one requester; round-robin pointer advanced on completion.
// Ports: clk, reset, req, advance, done_idx in; grant (one-hot), grant_idx out. Macro REG_ARB_FIXED_PRIO_EN.
module rr_arbiter #(
   parameter  int NUM_MASTERS = 2,
   localparam int IDX_W       = $clog2(NUM_MASTERS)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NUM_MASTERS-1:0] req,
   input  logic                   advance,
   input  logic [IDX_W-1:0]       done_idx,
   output logic [NUM_MASTERS-1:0] grant,
   output logic [IDX_W-1:0]       grant_idx
);

`ifdef REG_ARB_FIXED_PRIO_EN

   logic found;
   logic unused;

   assign unused = ^{clk, reset, advance, done_idx};

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         if (!found && req[i]) begin
            found     = 1'b1;
            grant[i]  = 1'b1;
            grant_idx = IDX_W'(i);
         end
      end
   end

`else

   logic [IDX_W-1:0] ptr_q;
   logic [IDX_W-1:0] ptr_d;
   logic             found;
   int               j;

   always_comb begin
      ptr_d = ptr_q;
      if (advance) begin
         if (done_idx == IDX_W'(NUM_MASTERS - 1))
            ptr_d = '0;
         else
            ptr_d = done_idx + 1'b1;
      end
   end

   // Search starts at the pointer itself and wraps around.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      j         = 0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         j = (int'(ptr_q) + i) % NUM_MASTERS;
         if (!found && req[j]) begin
            found     = 1'b1;
            grant[j]  = 1'b1;
            grant_idx = IDX_W'(j);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         ptr_q <= '0;
      else
         ptr_q <= ptr_d;
   end

`endif

endmodule

// File: rtl/reg_access_arbiter.sv
// reg_access_arbiter: shares one register map between NUM_MASTERS requesters.
// Ports: clk, reset (async high), bus (slave modport). Macro REG_ARB_FIXED_PRIO_EN.
module reg_access_arbiter
   import reg_arb_pkg::*;
#(
   parameter int NUM_MASTERS  = 2,
   parameter int REGS         = 5,
   parameter int POWEROF2REGS = 1 << $clog2(REGS),
   parameter int ADDR_W       = $clog2(POWEROF2REGS),
   parameter int DATA_W       = DATA_W_DEF
) (
   input logic               clk,
   input logic               reset,
   reg_access_arbiter_if.slave bus
);

   localparam int IDX_W = $clog2(NUM_MASTERS);

   arb_state_t              state_q, state_d;
   req_t                    req_q, req_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic                    err_q, err_d;
   logic [DATA_W-1:0]       rdata_q, rdata_d;
   logic [NUM_MASTERS-1:0]  rsp_valid_q, rsp_valid_d;

   logic [NUM_MASTERS-1:0]  grant;
   logic [IDX_W-1:0]        grant_idx;
   logic                    sel_write;
   logic [ADDR_W-1:0]       sel_addr;
   logic [DATA_W-1:0]       sel_wdata;
   logic [DATA_W-1:0]       rd_sel;
   logic                    acc_ok;

   rr_arbiter #(
      .NUM_MASTERS (NUM_MASTERS)
   ) u_arb (
      .clk       (clk),
      .reset     (reset),
      .req       (bus.req_valid),
      .advance   (state_q == RESP),
      .done_idx  (idx_q),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

   always_comb begin
      sel_write = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         if (grant_idx == IDX_W'(i)) begin
            sel_write = bus.req_write[i];
            sel_addr  = bus.req_addr[i*ADDR_W +: ADDR_W];
            sel_wdata = bus.req_wdata[i*DATA_W +: DATA_W];
         end
      end
   end

   always_comb begin
      rd_sel = '0;
      for (int p = 0; p < POWEROF2REGS; p++) begin
         if (req_q.addr == ADDR_W_MAX'(p))
            rd_sel = bus.data_out[p*DATA_W +: DATA_W];
      end
   end

   // Strobes decode straight from flops, so an async reset kills them at once.
   assign acc_ok = (state_q == ACCESS) && !err_q;

   always_comb begin
      bus.write_en = '0;
      bus.read_en  = '0;
      for (int p = 0; p < POWEROF2REGS; p++) begin
         if (req_q.addr == ADDR_W_MAX'(p)) begin
            bus.write_en[p] = acc_ok && req_q.write;
            bus.read_en[p]  = acc_ok && !req_q.write;
         end
      end
   end

   assign bus.data_in = (acc_ok && req_q.write) ?
                        DATA_W'(req_q.wdata) : '0;

   assign bus.req_ready = (state_q == IDLE && !reset) ?
                          grant : '0;

   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_rdata = rdata_q;
   assign bus.rsp_err   = (state_q == RESP) && err_q;

   always_comb begin
      state_d     = state_q;
      req_d       = req_q;
      idx_d       = idx_q;
      err_d       = err_q;
      rdata_d     = rdata_q;
      rsp_valid_d = '0;
      unique case (state_q)
         IDLE: begin
            if (|bus.req_valid) begin
               req_d.write = sel_write;
               req_d.addr  = ADDR_W_MAX'(sel_addr);
               req_d.wdata = DATA_W_DEF'(sel_wdata);
               idx_d       = grant_idx;
               err_d       = int'(32'(sel_addr)) >= REGS;
               state_d     = ACCESS;
            end
         end
         ACCESS: begin
            // Pre-pop read value is captured on the strobe edge.
            rdata_d = (!err_q && !req_q.write) ? rd_sel : '0;
            for (int i = 0; i < NUM_MASTERS; i++)
               rsp_valid_d[i] = (idx_q == IDX_W'(i));
            state_d = RESP;
         end
         RESP: begin
            rdata_d = '0;
            err_d   = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         req_q       <= '0;
         idx_q       <= '0;
         err_q       <= 1'b0;
         rdata_q     <= '0;
         rsp_valid_q <= '0;
      end else begin
         state_q     <= state_d;
         req_q       <= req_d;
         idx_q       <= idx_d;
         err_q       <= err_d;
         rdata_q     <= rdata_d;
         rsp_valid_q <= rsp_valid_d;
      end
   end

endmodule
